// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the one-bit-per-clock UART link
//               (receiver state encoding, line levels, default data width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Default number of data bits per frame, common to transmitter and receiver
  localparam int UART_DEFAULT_DATA_WIDTH = 8;

  // Serial line levels
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the serial receive line. Both flops
//               reset to the idle line level so that reset never produces a
//               false start bit. Used only when UART_RX_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronisation of the asynchronous line into the CLK domain
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_rx_sync

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : Serial-to-parallel receiver for the one-bit-per-clock UART
//               link. Frame = start(0), DATA_WIDTH data bits MSB-first,
//               stop(1). Emits a one-cycle valid pulse per good frame and a
//               one-cycle framing_error pulse when the stop bit is 0.
//               Optional macro UART_RX_SYNC_EN inserts a two-flop
//               synchronizer on rx (adds 2 cycles of latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  framing_error,
  output logic                  busy
);

  // Counter holds DATA_WIDTH-1 down to 0; width is clamped to at least 1 bit
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

  logic                  rx_s;

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q,  ferr_d;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_rx_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d_i   (rx),
    .q_o   (rx_s)
  );
`else
  // Transmitter shares CLK, so the line is already synchronous
  assign rx_s = rx;
`endif

  // State and datapath registers; reset discards any frame in progress
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: track frame position, shift in data, judge the stop bit
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_s == UART_START_LEVEL) begin
          state_d = DATA;
          cnt_d   = CNT_LOAD;
        end
      end

      DATA: begin
        // First data bit received ends up as the MSB
        shift_d = {shift_q[DATA_WIDTH-2:0], rx_s};
        if (cnt_q == '0) begin
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      STOP: begin
        if (rx_s == UART_STOP_LEVEL) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          // Keep the last good word; wait out the low line in BREAK
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end

      BREAK: begin
        // A held-low line must not be taken as a fresh start bit
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule : uart_receiver

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver. A scoreboard queue
//               receives each expected byte and its start cycle when a frame
//               is driven; a monitor pops and compares on every valid pulse.
//               Expected latency follows UART_RX_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int DW = 8;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = DW + 4;
`else
  localparam int LAT = DW + 2;
`endif

  logic          CLK   = 1'b0;
  logic          RESET = 1'b1;
  logic          rx    = 1'b1;
  logic [DW-1:0] data;
  logic          valid;
  logic          framing_error;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_valid        = 0;
  int n_ferr         = 0;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;
  int last_ferr_cyc  = -1;

  uart_receiver #(.DATA_WIDTH(DW)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: scoreboard compare on valid, record framing errors
  always @(negedge CLK) begin
    if (!RESET && (valid || framing_error)) begin
      n_checks++;
      if (valid && framing_error) begin
        n_errors++;
        $display("FAIL exclusive_pulses: valid=%b framing_error=%b, required not both 1", valid, framing_error);
      end
      if (valid) begin
        n_valid++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_valid: data=%h at cycle %0d, required no pulse", data, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (data !== mon_e.d) begin
            n_errors++;
            $display("FAIL sb_data: got %h, required %h", data, mon_e.d);
          end
          n_checks++;
          if (cyc - mon_e.c !== LAT) begin
            n_errors++;
            $display("FAIL sb_latency: got %0d cycles, required %0d", cyc - mon_e.c, LAT);
          end
        end
      end
      if (framing_error) begin
        n_ferr++;
        last_ferr_cyc = cyc;
      end
    end
  end

  task automatic send_bit(input logic b);
    @(posedge CLK);
    #1;
    rx = b;
  endtask

  task automatic send_frame(input logic [DW-1:0] v, input logic stop_b,
                            input bit push, output int start);
    send_bit(1'b0);
    start = cyc;
    if (push) sb.push_back('{d: v, c: start});
    for (int i = DW - 1; i >= 0; i--) send_bit(v[i]);
    send_bit(stop_b);
  endtask

  task automatic drain(input string name);
    send_bit(1'b1);
    repeat (LAT + 2) @(posedge CLK);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing_valid: %0d frames outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    rx    = 1'b1;
    #2;
    n_checks++;
    if ({valid, framing_error, busy} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: valid/ferr/busy=%b, required 000", {valid, framing_error, busy});
    end
    n_checks++;
    if (data !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got %h, required 00", data);
    end
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_idle();
    int v0, f0;
    bit busy_seen;
    v0 = n_valid;
    f0 = n_ferr;
    busy_seen = 0;
    rx = 1'b1;
    repeat (30) begin
      @(negedge CLK);
      if (busy) busy_seen = 1;
    end
    n_checks++;
    if (busy_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_busy: busy seen=%b, required 0", busy_seen);
    end
    n_checks++;
    if ((n_valid - v0) != 0 || (n_ferr - f0) != 0) begin
      n_errors++;
      $display("FAIL idle_pulses: valid=%0d ferr=%0d, required 0 0", n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_single_frame();
    int v0, f0, st;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b1, st);
    drain("single");
    n_checks++;
    if ((n_valid - v0) != 1 || (n_ferr - f0) != 0) begin
      n_errors++;
      $display("FAIL single_counts: valid=%0d ferr=%0d, required 1 0", n_valid - v0, n_ferr - f0);
    end
    n_checks++;
    if (data !== 8'hA5) begin
      n_errors++;
      $display("FAIL single_data_hold: got %h, required a5", data);
    end
  endtask

  task automatic test_back_to_back();
    int v0, st;
    v0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b1, st);
    send_frame(8'hFF, 1'b1, 1'b1, st);
    drain("b2b");
    n_checks++;
    if ((n_valid - v0) != 2) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d valid pulses, required 2", n_valid - v0);
    end
    n_checks++;
    if (last_valid_cyc - prev_valid_cyc != DW + 2) begin
      n_errors++;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d", last_valid_cyc - prev_valid_cyc, DW + 2);
    end
    n_checks++;
    if (data !== 8'hFF) begin
      n_errors++;
      $display("FAIL b2b_data: got %h, required ff", data);
    end
  endtask

  task automatic test_framing_error();
    int v0, f0, st;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, st);
    repeat (5) send_bit(1'b0);
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ferr_busy_held: got %b, required 1", busy);
    end
    send_bit(1'b1);
    repeat (4) @(posedge CLK);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ferr_busy_release: got %b, required 0", busy);
    end
    n_checks++;
    if ((n_ferr - f0) != 1 || (n_valid - v0) != 0) begin
      n_errors++;
      $display("FAIL ferr_counts: ferr=%0d valid=%0d, required 1 0", n_ferr - f0, n_valid - v0);
    end
    n_checks++;
    if (last_ferr_cyc - st != LAT) begin
      n_errors++;
      $display("FAIL ferr_latency: got %0d cycles, required %0d", last_ferr_cyc - st, LAT);
    end
    n_checks++;
    if (data !== 8'hFF) begin
      n_errors++;
      $display("FAIL ferr_data_kept: got %h, required ff", data);
    end
    send_frame(8'h81, 1'b1, 1'b1, st);
    drain("after_ferr");
    n_checks++;
    if (data !== 8'h81) begin
      n_errors++;
      $display("FAIL after_ferr_data: got %h, required 81", data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0, st;
    logic [DW-1:0] v;
    v  = 8'hC3;
    v0 = n_valid;
    f0 = n_ferr;
    send_bit(1'b0);
    for (int i = DW - 1; i >= DW - 4; i--) send_bit(v[i]);
    @(posedge CLK);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_busy_before: got %b, required 1", busy);
    end
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({valid, framing_error, busy} !== 3'b000 || data !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: flags=%b data=%h, required 000 00", {valid, framing_error, busy}, data);
    end
    rx = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (LAT + 2) @(posedge CLK);
    #1;
    n_checks++;
    if ((n_valid - v0) != 0 || (n_ferr - f0) != 0) begin
      n_errors++;
      $display("FAIL midrst_no_pulse: valid=%0d ferr=%0d, required 0 0", n_valid - v0, n_ferr - f0);
    end
    send_frame(8'h5A, 1'b1, 1'b1, st);
    drain("midrst");
    n_checks++;
    if (data !== 8'h5A) begin
      n_errors++;
      $display("FAIL midrst_data: got %h, required 5a", data);
    end
  endtask

  task automatic test_loopback();
    int v0, st;
    logic [DW-1:0] b;
    v0 = n_valid;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 3)) send_bit(1'b1);
      b = DW'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b1, st);
    end
    drain("loopback");
    n_checks++;
    if ((n_valid - v0) != 200) begin
      n_errors++;
      $display("FAIL loopback_count: got %0d bytes, required 200", n_valid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_back_to_back();
    test_framing_error();
    test_reset_mid_frame();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish before 1ms");
    $fatal(1);
  end

endmodule : tb_uart_receiver

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receiver for the one-bit-per-clock UART link. It sits directly downstream of `uart_transmitter` and samples the `tx` line on every `CLK` rising edge. It reconstructs each frame: start bit 0, `DATA_WIDTH` data bits MSB-first, stop bit 1. For each good frame it presents the byte with a one-cycle valid pulse, and it flags frames whose stop bit is 0.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; must be ≥ 2.
- `CLK`  in  1  clock; all sampling on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle level 1; connects to the transmitter's `tx`.
- `data`  out  `DATA_WIDTH`  last correctly received word; holds until the next good frame.
- `valid`  out  1  one-cycle pulse; `data` is new in that cycle.
- `framing_error`  out  1  one-cycle pulse; stop bit was sampled 0.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- Sampled line `rx_s`: equals `rx` directly, or the synchronizer output when that is enabled (see Configuration).
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0.
- No backpressure. The consumer must capture `data` while `valid` is high.
- State IDLE:
  - `rx_s`=0 → go to DATA; load counter = `DATA_WIDTH`-1.
  - `rx_s`=1 → stay in IDLE.
- State DATA:
  - Shift each sample in at the LSB: shift = {shift[`DATA_WIDTH`-2:0], `rx_s`}, so the first data bit ends up as the MSB.
  - Counter = 0 → go to STOP; otherwise decrement the counter.
- State STOP:
  - `rx_s`=1 → `data` <= shift, `valid` <= 1, go to IDLE.
  - `rx_s`=0 → `framing_error` <= 1; `data` is unchanged; go to BREAK.
- State BREAK: wait for `rx_s`=1, then go to IDLE. This stops a held-low line from being read as a new start bit.
- Back-to-back frames are supported. A start bit may arrive on the edge right after the stop-bit edge. The receiver is then already back in IDLE and accepts it with no lost cycle.
- Counter width is $clog2(`DATA_WIDTH`). Decrement stops at 0 and never wraps.
- RESET mid-frame: the frame is discarded, no `valid` and no `framing_error`. After release, the first `rx_s`=0 is treated as a start bit. The transmitter shares `RESET`, so both ends restart in idle together.

## Timing
- Frame length: 1 + `DATA_WIDTH` + 1 edges; 10 for the default.
- Start bit sampled at edge E0, data bits at E1..E`DATA_WIDTH`, stop bit at E`DATA_WIDTH`+1.
- `valid` or `framing_error` is registered at the stop edge and is high for exactly the following cycle.
- End-to-end latency is counted from the transmitter's start-bit cycle to `valid`:
  - without the synchronizer: `DATA_WIDTH`+2 cycles;
  - with the synchronizer: `DATA_WIDTH`+4 cycles.
- `valid` and `framing_error` are never high in the same cycle.
- `busy` rises the cycle after E0 and falls the cycle after the stop edge (or after the BREAK exit).

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rx` passes through a two-flop synchronizer before use; both flops reset to 1.
  - This adds 2 cycles of latency; all other behaviour is identical.
- Not defined: `rx` is used directly, which is legal only when the transmitter shares `CLK`.

## Structure
- Shared package `uart_pkg`:
  - receiver state enum {IDLE, DATA, STOP, BREAK};
  - constants `UART_IDLE_LEVEL`=1, `UART_START_LEVEL`=0, `UART_STOP_LEVEL`=1;
  - default data width 8, shared with the transmitter.
- One sub-module, `uart_rx_sync`: the two-flop synchronizer with reset value 1, instantiated only under `UART_RX_SYNC_EN`.

## Test plan
- Idle: `rx`=1 for 30 cycles → `valid`, `framing_error` and `busy` stay 0.
- Single frame: `rx` = 0,1,0,1,0,0,1,0,1,1 → one `valid` pulse with `data`=0xA5, the cycle after the 10th edge; `framing_error` stays 0.
- Back-to-back: 0x00 then 0xFF with no idle gap → two `valid` pulses exactly 10 cycles apart; `data`=0x00, then 0xFF.
- Framing error: frame for 0x3C with stop bit 0, then `rx` held 0 for 5 more cycles → one `framing_error` pulse, no `valid`, `data` unchanged, `busy` high until `rx`=1. A following 0x81 frame is then received correctly.
- Reset mid-frame: assert `RESET` after data bit 4 → outputs 0 immediately and no pulse. After release with `rx`=1, a 0x5A frame gives `valid` with `data`=0x5A.
- Loopback with `uart_transmitter`: 200 random bytes with random idle gaps of 0–3 cycles → every byte is received in order. Run once with the macro undefined (latency 10 cycles) and once with `UART_RX_SYNC_EN` (latency 12 cycles).
